// File: rtl/retospect_lif_cell_if.sv
// Bundles the scan-chain and neuron signal lines of one retospect_lif_cell.
// The master side drives config, clockbus and dendrites; the slave side is the cell.
interface retospect_lif_cell_if #(
    parameter int N_DEND = 4,
    parameter int P_BITS = 6,
    parameter int S_BITS = 3
);
    logic                   config_en;
    logic                   bs_in;
    logic                   bs_out;
    logic [2**S_BITS-1:0]   clockbus;
    logic [N_DEND-1:0]      dendrite;
    logic                   axon;
    logic [P_BITS-1:0]      v_out;

    modport master (
        output config_en, bs_in, clockbus, dendrite,
        input  bs_out, axon, v_out
    );

    modport slave (
        input  config_en, bs_in, clockbus, dendrite,
        output bs_out, axon, v_out
    );
endinterface

// File: rtl/retospect_lif_cell.sv
// Leaky integrate-and-fire neuron with scan-chain configuration, selectable leak,
// refractory period and zero/subtract post-fire reset.
module retospect_lif_cell #(
    parameter int N_DEND = 4,
    parameter int W_BITS = 4,
    parameter int P_BITS = 6,
    parameter int S_BITS = 3,
    parameter int R_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reset_nn,
    retospect_lif_cell_if.slave  io
);
    localparam int CFG_LEN = N_DEND*W_BITS + P_BITS + S_BITS + R_BITS + 2;
    localparam int SUM_W   = P_BITS + W_BITS + $clog2(N_DEND) + 1;
    localparam int THR_LSB = N_DEND*W_BITS;
    localparam int SEL_LSB = THR_LSB + P_BITS;
    localparam int RL_LSB  = SEL_LSB + S_BITS;
    localparam int LM_BIT  = RL_LSB + R_BITS;
    localparam int FM_BIT  = LM_BIT + 1;

    logic [CFG_LEN-1:0]      cfg_q, cfg_d;
    logic [P_BITS-1:0]       v_q, v_d;
    logic [R_BITS-1:0]       refr_cnt_q, refr_cnt_d;
    logic                    axon_q, axon_d;

    logic [P_BITS-1:0]       thr;
    logic [S_BITS-1:0]       leak_sel;
    logic [R_BITS-1:0]       refr_len;
    logic                    leak_mode;
    logic                    fire_mode;

    logic [P_BITS-1:0]       v_l;
    logic [P_BITS-1:0]       v_n;
    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] v_sum;
    logic                    fire;

    assign thr       = cfg_q[THR_LSB +: P_BITS];
    assign leak_sel  = cfg_q[SEL_LSB +: S_BITS];
    assign refr_len  = cfg_q[RL_LSB +: R_BITS];
    assign leak_mode = cfg_q[LM_BIT];
    assign fire_mode = cfg_q[FM_BIT];

    // Clamp the wide signed membrane sum into the unsigned potential range.
    function automatic logic [P_BITS-1:0] sat_pot(input logic signed [SUM_W-1:0] x);
        if (x[SUM_W-1])
            return '0;
        else if (|x[SUM_W-2:P_BITS])
            return '1;
        else
            return x[P_BITS-1:0];
    endfunction

    always_comb begin
        v_l = v_q;
        if (io.clockbus[leak_sel]) begin
            if (leak_mode)
                v_l = (v_q == '0) ? '0 : v_q - P_BITS'(1);
            else
                v_l = v_q >> 1;
        end

        // Every active dendrite contributes; weights are sign-extended first.
        sum_s = '0;
        for (int i = 0; i < N_DEND; i++) begin
            if (io.dendrite[i])
                sum_s = sum_s + $signed({{(SUM_W-W_BITS){cfg_q[i*W_BITS + W_BITS - 1]}},
                                         cfg_q[i*W_BITS +: W_BITS]});
        end
        v_sum = $signed({{(SUM_W-P_BITS){1'b0}}, v_l}) + sum_s;
        v_n   = sat_pot(v_sum);
        fire  = (thr != '0) && (v_n >= thr);
    end

    always_comb begin
        cfg_d      = cfg_q;
        v_d        = v_q;
        refr_cnt_d = refr_cnt_q;
        axon_d     = 1'b0;
        if (reset) begin
            cfg_d      = '0;
            v_d        = '0;
            refr_cnt_d = '0;
        end else if (reset_nn) begin
            v_d        = P_BITS'(1);
            refr_cnt_d = '0;
        end else if (io.config_en) begin
            cfg_d = {io.bs_in, cfg_q[CFG_LEN-1:1]};
        end else if (refr_cnt_q != '0) begin
            refr_cnt_d = refr_cnt_q - R_BITS'(1);
            v_d        = v_l;
        end else if (fire) begin
            axon_d     = 1'b1;
            refr_cnt_d = refr_len;
            v_d        = fire_mode ? (v_n - thr) : '0;
        end else begin
            v_d = v_n;
        end
    end

    always_ff @(posedge clk) begin
        cfg_q      <= cfg_d;
        v_q        <= v_d;
        refr_cnt_q <= refr_cnt_d;
        axon_q     <= axon_d;
    end

    assign io.bs_out = cfg_q[0];
    assign io.axon   = axon_q;
    assign io.v_out  = v_q;
endmodule

// File: tb/tb_retospect_lif_cell.sv
// Directed bench for retospect_lif_cell: scan chain, integrate/fire, saturation,
// refractory, leak modes and control priority with hand-computed expectations.
module tb_retospect_lif_cell;
    logic clk;
    logic reset;
    logic reset_nn;
    int   n_assert;
    int   n_fail;

    retospect_lif_cell_if #(.N_DEND(4), .P_BITS(6), .S_BITS(3)) bus ();

    retospect_lif_cell #(
        .N_DEND(4), .W_BITS(4), .P_BITS(6), .S_BITS(3), .R_BITS(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .reset_nn (reset_nn),
        .io       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] mk_cfg(input logic [3:0] w0, input logic [3:0] w1,
                                           input logic [3:0] w2, input logic [3:0] w3,
                                           input logic [5:0] thr, input logic [2:0] sel,
                                           input logic [2:0] rl, input logic lm,
                                           input logic fm);
        return {fm, lm, rl, sel, thr, w3, w2, w1, w0};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_cfg(input logic [29:0] c);
        bus.dendrite  = '0;
        bus.config_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.bs_in = c[i];
            tick();
        end
        bus.config_en = 1'b0;
        bus.bs_in     = 1'b0;
    endtask

    task automatic step(input string tag, input logic [3:0] dend, input int ev, input int ea);
        bus.dendrite = dend;
        tick();
        chk({tag, "_v"}, 32'(bus.v_out), ev);
        chk({tag, "_ax"}, 32'(bus.axon), ea);
    endtask

    logic [29:0] pat;

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        reset_nn      = 1'b0;
        bus.config_en = 1'b0;
        bus.bs_in     = 1'b0;
        bus.clockbus  = '0;
        bus.dendrite  = '0;
        pat           = 30'h2AAAAAAA;

        // Reset state
        tick();
        chk("rst_v", 32'(bus.v_out), 0);
        chk("rst_ax", 32'(bus.axon), 0);
        chk("rst_bs", 32'(bus.bs_out), 0);
        reset = 1'b0;

        // Scan chain: pattern in, then replay on bs_out while shifting zeros
        bus.config_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.bs_in = pat[i];
            if (i == 29) chk("scan_pre", 32'(bus.bs_out), 0);
            tick();
        end
        bus.bs_in = 1'b0;
        for (int k = 0; k < 30; k++) begin
            chk($sformatf("scan_out%0d", k), 32'(bus.bs_out), 32'(pat[k]));
            tick();
        end
        bus.config_en = 1'b0;
        chk("scan_v", 32'(bus.v_out), 0);

        // Integrate and fire, zero reset
        do_reset();
        load_cfg(mk_cfg(4'd3, 4'd0, 4'd0, 4'd0, 6'd8, 3'd0, 3'd0, 1'b0, 1'b0));
        step("if1", 4'b0001, 3, 0);
        step("if2", 4'b0001, 6, 0);
        step("if3", 4'b0001, 0, 1);
        step("if4", 4'b0000, 0, 0);

        // Integrate and fire, subtract reset
        do_reset();
        load_cfg(mk_cfg(4'd3, 4'd0, 4'd0, 4'd0, 6'd8, 3'd0, 3'd0, 1'b0, 1'b1));
        step("sub1", 4'b0001, 3, 0);
        step("sub2", 4'b0001, 6, 0);
        step("sub3", 4'b0001, 1, 1);
        step("sub4", 4'b0000, 1, 0);

        // Signed sum with lower saturation
        do_reset();
        load_cfg(mk_cfg(4'd5, 4'hE, 4'd0, 4'd0, 6'd0, 3'd0, 3'd0, 1'b0, 1'b0));
        step("sgn1", 4'b0011, 3, 0);
        step("sgn2", 4'b0011, 6, 0);
        step("sgn3", 4'b0010, 4, 0);
        step("sgn4", 4'b0010, 2, 0);
        step("sgn5", 4'b0010, 0, 0);
        step("sgn6", 4'b0010, 0, 0);

        // Upper saturation, firing disabled
        do_reset();
        load_cfg(mk_cfg(4'd7, 4'd7, 4'd7, 4'd7, 6'd0, 3'd0, 3'd0, 1'b0, 1'b0));
        step("sat1", 4'b1111, 28, 0);
        step("sat2", 4'b1111, 56, 0);
        step("sat3", 4'b1111, 63, 0);

        // Refractory period
        do_reset();
        load_cfg(mk_cfg(4'd7, 4'd0, 4'd0, 4'd0, 6'd5, 3'd0, 3'd2, 1'b0, 1'b0));
        step("ref1", 4'b0001, 0, 1);
        step("ref2", 4'b0001, 0, 0);
        step("ref3", 4'b0001, 0, 0);
        step("ref4", 4'b0001, 0, 1);
        step("ref5", 4'b0001, 0, 0);

        // Leak by halving from 40
        do_reset();
        load_cfg(mk_cfg(4'd7, 4'd5, 4'd0, 4'd0, 6'd0, 3'd7, 3'd0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) step("pre", 4'b0001, 7*(i+1), 0);
        step("pre6", 4'b0010, 40, 0);
        bus.clockbus = 8'h80;
        step("lk1", 4'b0000, 20, 0);
        step("lk2", 4'b0000, 10, 0);
        step("lk3", 4'b0000, 5, 0);
        step("lk4", 4'b0000, 2, 0);
        step("lk5", 4'b0000, 1, 0);
        step("lk6", 4'b0000, 0, 0);

        // Leak by decrement, then network reset mid-leak
        bus.clockbus = '0;
        load_cfg(mk_cfg(4'd7, 4'd5, 4'd0, 4'd0, 6'd0, 3'd7, 3'd0, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++) step("pre", 4'b0001, 7*(i+1), 0);
        step("pre6b", 4'b0010, 40, 0);
        bus.clockbus = 8'h80;
        step("dec1", 4'b0000, 39, 0);
        step("dec2", 4'b0000, 38, 0);
        step("dec3", 4'b0000, 37, 0);
        reset_nn = 1'b1;
        step("nn", 4'b0000, 1, 0);
        reset_nn = 1'b0;
        step("nn_lm", 4'b0000, 0, 0);
        step("nn_w0", 4'b0001, 7, 0);
        bus.clockbus = '0;

        // config_en beats run and clears axon
        do_reset();
        load_cfg(mk_cfg(4'd7, 4'd0, 4'd0, 4'd0, 6'd5, 3'd0, 3'd0, 1'b0, 1'b1));
        step("pri_fire", 4'b0001, 2, 1);
        bus.config_en = 1'b1;
        bus.bs_in     = 1'b1;
        step("pri_cfg", 4'b1111, 2, 0);

        // reset beats config_en: whole chain reads back zero
        reset = 1'b1;
        step("pri_rst", 4'b1111, 0, 0);
        reset = 1'b0;
        bus.bs_in    = 1'b0;
        bus.dendrite = '0;
        for (int k = 0; k < 30; k++) begin
            chk($sformatf("rst_cfg%0d", k), 32'(bus.bs_out), 0);
            tick();
        end
        bus.config_en = 1'b0;

        // Reset during refractory leaves no refractory count behind
        do_reset();
        load_cfg(mk_cfg(4'd7, 4'd0, 4'd0, 4'd0, 6'd5, 3'd0, 3'd7, 1'b0, 1'b0));
        step("rr1", 4'b0001, 0, 1);
        step("rr2", 4'b0001, 0, 0);
        reset = 1'b1;
        step("rr_rst", 4'b0000, 0, 0);
        reset = 1'b0;
        load_cfg(mk_cfg(4'd7, 4'd0, 4'd0, 4'd0, 6'd5, 3'd0, 3'd7, 1'b0, 1'b0));
        step("rr3", 4'b0001, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
